// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the boot-time instruction memory loader.
// The RECV_CSUM encoding is only reached when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

    localparam int INSTR_W   = 16;
    localparam int ADDR_W    = 8;
    localparam int MEM_DEPTH = 256;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RECV_HI   = 3'd1,
        RECV_LO   = 3'd2,
        WRITE     = 3'd3,
        DONE      = 3'd4,
        ERROR     = 3'd5,
        RECV_CSUM = 3'd6
    } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream plus instruction memory write port of the loader.
// The loader is the slave; the host/memory side is the master.
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int INSTR_WIDTH = INSTR_W,
    parameter int ADDR_WIDTH  = ADDR_W
);

    logic                   in_valid;
    logic [7:0]             in_data;
    logic                   in_ready;
    logic                   imem_we;
    logic [ADDR_WIDTH-1:0]  imem_addr;
    logic [INSTR_WIDTH-1:0] imem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/imem_loader_byte_rx.sv
// Valid/ready byte capture and high/low word assembly for the loader.
// With IMEM_LOADER_CHECKSUM_EN it also keeps the running XOR of data bytes.
module imem_loader_byte_rx
    import imem_loader_pkg::*;
#(
    parameter int INSTR_WIDTH = INSTR_W
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   hi_en_i,
    input  logic                   lo_en_i,
`ifdef IMEM_LOADER_CHECKSUM_EN
    input  logic                   csum_en_i,
    input  logic                   clear_i,
    output logic                   csum_ok_o,
`endif
    input  logic                   in_valid_i,
    input  logic [7:0]             in_data_i,
    output logic                   in_ready_o,
    output logic                   accept_o,
    output logic [INSTR_WIDTH-1:0] wdata_o
);

    logic [7:0]             hi_q, hi_d;
    logic [INSTR_WIDTH-1:0] wdata_q, wdata_d;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    assign in_ready_o = hi_en_i | lo_en_i | csum_en_i;
    assign csum_ok_o  = (in_data_i == csum_q);

    // The checksum covers data bytes only, never the checksum byte itself.
    always_comb begin
        csum_d = csum_q;
        if (clear_i)
            csum_d = 8'h00;
        else if (accept_o && (hi_en_i || lo_en_i))
            csum_d = csum_q ^ in_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            csum_q <= 8'h00;
        else
            csum_q <= csum_d;
    end
`else
    assign in_ready_o = hi_en_i | lo_en_i;
`endif

    assign accept_o = in_valid_i & in_ready_o;
    assign wdata_o  = wdata_q;

    always_comb begin
        hi_d    = hi_q;
        wdata_d = wdata_q;
        if (accept_o && hi_en_i)
            hi_d = in_data_i;
        if (accept_o && lo_en_i)
            wdata_d = INSTR_WIDTH'({hi_q, in_data_i});
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hi_q    <= 8'h00;
            wdata_q <= '0;
        end else begin
            hi_q    <= hi_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams host bytes into instruction memory, then releases the CPU via cpu_run.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per session.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int INSTR_WIDTH = INSTR_W,
    parameter int ADDR_WIDTH  = ADDR_W,
    parameter int DEPTH       = MEM_DEPTH
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load_start,
    input  logic [ADDR_WIDTH:0] load_count,
    imem_loader_if.slave        bus,
    output logic                busy,
    output logic                cpu_run,
    output logic                load_error
);

    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e AFTER_LAST = RECV_CSUM;
    logic csum_ok;
`else
    localparam state_e AFTER_LAST = DONE;
`endif

    state_e                 state_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [ADDR_WIDTH:0]    count_q;
    logic                   accept;
    logic                   start_ok;
    logic                   last_word;
    logic [INSTR_WIDTH-1:0] wdata;

    // A new session may only begin while no transfer is in flight.
    assign start_ok  = load_start &&
                       (state_q == IDLE || state_q == DONE || state_q == ERROR);
    assign last_word = ({1'b0, addr_q} == (count_q - 1'b1));

    imem_loader_byte_rx #(
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_byte_rx (
        .clk_i      (clock),
        .rst_ni     (reset),
        .hi_en_i    (state_q == RECV_HI),
        .lo_en_i    (state_q == RECV_LO),
`ifdef IMEM_LOADER_CHECKSUM_EN
        .csum_en_i  (state_q == RECV_CSUM),
        .clear_i    (start_ok),
        .csum_ok_o  (csum_ok),
`endif
        .in_valid_i (bus.in_valid),
        .in_data_i  (bus.in_data),
        .in_ready_o (bus.in_ready),
        .accept_o   (accept),
        .wdata_o    (wdata)
    );

    assign bus.imem_we    = (state_q == WRITE);
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata;
    assign busy           = (state_q == RECV_HI) || (state_q == RECV_LO) ||
                            (state_q == WRITE)   || (state_q == RECV_CSUM);
    assign cpu_run        = (state_q == DONE);
    assign load_error     = (state_q == ERROR);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (start_ok) begin
                        count_q <= load_count;
                        addr_q  <= '0;
                        if (load_count == '0)
                            state_q <= AFTER_LAST;
                        else if (load_count > DEPTH_L)
                            state_q <= ERROR;
                        else
                            state_q <= RECV_HI;
                    end
                end
                RECV_HI: if (accept) state_q <= RECV_LO;
                RECV_LO: if (accept) state_q <= WRITE;
                WRITE: begin
                    if (last_word) begin
                        state_q <= AFTER_LAST;
                    end else begin
                        addr_q  <= addr_q + 1'b1;
                        state_q <= RECV_HI;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                RECV_CSUM: if (accept) state_q <= csum_ok ? DONE : ERROR;
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized byte sessions checked against a word-list model.
// Honors IMEM_LOADER_CHECKSUM_EN by appending the XOR checksum byte to each session.
module tb_imem_loader;

    logic       clock = 1'b0;
    logic       reset;
    logic       load_start;
    logic [8:0] load_count;
    logic       busy;
    logic       cpu_run;
    logic       load_error;

    int numChecks = 0;
    int numFails  = 0;
    int cycle     = 0;

    logic [7:0] txBytes[$];
    int         wrAddr[$];
    int         wrData[$];
    int         wrCycle[$];

    imem_loader_if bus ();

    imem_loader dut (
        .clock      (clock),
        .reset      (reset),
        .load_start (load_start),
        .load_count (load_count),
        .bus        (bus),
        .busy       (busy),
        .cpu_run    (cpu_run),
        .load_error (load_error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    // Memory-side monitor: every write the loader issues, with the cycle it appeared in.
    always @(negedge clock) begin
        if (bus.imem_we === 1'b1) begin
            wrAddr.push_back(int'(bus.imem_addr));
            wrData.push_back(int'(bus.imem_wdata));
            wrCycle.push_back(cycle);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic clearWrites();
        wrAddr.delete();
        wrData.delete();
        wrCycle.delete();
    endtask

    task automatic pulseStart(input int count);
        load_count = 9'(count);
        load_start = 1'b1;
        @(posedge clock); #1;
        load_start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        bit accepted;
        bit rdy;
        accepted = 1'b0;
        if (gap > 0) begin
            bus.in_valid = 1'b0;
            repeat (gap) @(posedge clock);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clock);
            rdy = bus.in_ready;
            @(posedge clock); #1;
            if (rdy) accepted = 1'b1;
        end
        if (!accepted) checkOutput("byte accept timeout", 32'(accepted), 32'd1);
    endtask

    function automatic logic [7:0] xorOf();
        logic [7:0] x = 8'h00;
        foreach (txBytes[i]) x ^= txBytes[i];
        return x;
    endfunction

    // One full session: start pulse, every byte of txBytes, optional checksum (flipped on request).
    task automatic applyStimulus(input int count, input int maxGap, input logic [7:0] csumFlip);
        clearWrites();
        bus.in_valid = 1'b0;
        pulseStart(count);
        foreach (txBytes[i]) sendByte(txBytes[i], $urandom_range(0, maxGap));
`ifdef IMEM_LOADER_CHECKSUM_EN
        sendByte(xorOf() ^ csumFlip, $urandom_range(0, maxGap));
`else
        if (csumFlip != 8'h00) $display("[TB] note: checksum flip ignored without checksum build");
`endif
        bus.in_valid = 1'b0;
    endtask

    task automatic waitSettled(input string tag);
        bit settled = 1'b0;
        for (int i = 0; i < 20 && !settled; i++) begin
            @(negedge clock);
            if (cpu_run || load_error) settled = 1'b1;
        end
        checkOutput({tag, " settle"}, 32'(settled), 32'd1);
        @(posedge clock); #1;
    endtask

    task automatic fillRandom(input int count);
        txBytes.delete();
        for (int i = 0; i < 2 * count; i++) txBytes.push_back(8'($urandom));
    endtask

    // Expected outcome of a good session: word i = {byte 2i, byte 2i+1} at address i, then run.
    task automatic checkSession(input int count, input string tag);
        int n;
        checkOutput({tag, " write count"}, 32'(wrAddr.size()), 32'(count));
        n = (wrAddr.size() < count) ? wrAddr.size() : count;
        for (int i = 0; i < n; i++) begin
            checkOutput({tag, " addr"}, 32'(wrAddr[i]), 32'(i));
            checkOutput({tag, " data"}, 32'(wrData[i]), {16'h0, txBytes[2*i], txBytes[2*i+1]});
        end
        checkOutput({tag, " cpu_run"}, 32'(cpu_run), 32'd1);
        checkOutput({tag, " busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " load_error"}, 32'(load_error), 32'd0);
        checkOutput({tag, " in_ready"}, 32'(bus.in_ready), 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " in_ready"}, 32'(bus.in_ready), 32'd0);
        checkOutput({tag, " imem_we"}, 32'(bus.imem_we), 32'd0);
        checkOutput({tag, " imem_addr"}, 32'(bus.imem_addr), 32'd0);
        checkOutput({tag, " imem_wdata"}, 32'(bus.imem_wdata), 32'd0);
        checkOutput({tag, " busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " cpu_run"}, 32'(cpu_run), 32'd0);
        checkOutput({tag, " load_error"}, 32'(load_error), 32'd0);
    endtask

    initial begin
        bit stallWrote;
        bit stallHeld;

        reset        = 1'b0;
        load_start   = 1'b0;
        load_count   = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clock);
        checkAllZero("reset");
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;

        // Directed two-word load with valid held high: 3-cycle spacing.
        txBytes = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        applyStimulus(2, 0, 8'h00);
        waitSettled("two words");
        checkSession(2, "two words");
        if (wrCycle.size() == 2)
            checkOutput("two words spacing", 32'(wrCycle[1] - wrCycle[0]), 32'd3);

        // Host stalls five cycles between the high and low byte.
        fillRandom(1);
        clearWrites();
        pulseStart(1);
        sendByte(txBytes[0], 0);
        bus.in_valid = 1'b0;
        stallWrote = 1'b0;
        stallHeld  = 1'b1;
        repeat (5) begin
            @(negedge clock);
            if (bus.imem_we) stallWrote = 1'b1;
            if (!(bus.in_ready && busy)) stallHeld = 1'b0;
        end
        @(posedge clock); #1;
        checkOutput("stall no write", 32'(stallWrote), 32'd0);
        checkOutput("stall held", 32'(stallHeld), 32'd1);
        sendByte(txBytes[1], 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        sendByte(xorOf(), 0);
`endif
        bus.in_valid = 1'b0;
        waitSettled("stall");
        checkSession(1, "stall");

        // Over-size count is rejected.
        clearWrites();
        pulseStart(257);
        @(negedge clock);
        checkOutput("count257 load_error", 32'(load_error), 32'd1);
        checkOutput("count257 in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("count257 cpu_run", 32'(cpu_run), 32'd0);
        checkOutput("count257 busy", 32'(busy), 32'd0);
        @(posedge clock); #1;

        // Zero-word session.
        txBytes.delete();
`ifdef IMEM_LOADER_CHECKSUM_EN
        applyStimulus(0, 0, 8'h00);
        waitSettled("count0");
`else
        clearWrites();
        pulseStart(0);
        @(negedge clock);
        @(posedge clock); #1;
`endif
        checkSession(0, "count0");

        // load_start while busy is ignored.
        fillRandom(3);
        clearWrites();
        pulseStart(3);
        for (int i = 0; i < 3; i++) sendByte(txBytes[i], 0);
        bus.in_valid = 1'b0;
        pulseStart(1);
        checkOutput("busy start ignored", 32'(busy), 32'd1);
        for (int i = 3; i < 6; i++) sendByte(txBytes[i], 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        sendByte(xorOf(), 0);
`endif
        bus.in_valid = 1'b0;
        waitSettled("busy start");
        checkSession(3, "busy start");

        // Randomized sessions with random host gaps.
        for (int s = 0; s < 10; s++) begin
            int cnt;
            cnt = $urandom_range(1, 8);
            fillRandom(cnt);
            applyStimulus(cnt, 3, 8'h00);
            waitSettled("random");
            checkSession(cnt, "random");
        end

        // Full-depth load: last write lands at DEPTH-1.
        fillRandom(256);
        applyStimulus(256, 0, 8'h00);
        waitSettled("depth");
        checkSession(256, "depth");

`ifdef IMEM_LOADER_CHECKSUM_EN
        txBytes = '{8'h12, 8'h34};
        applyStimulus(1, 0, 8'h00);
        waitSettled("csum good");
        checkOutput("csum good cpu_run", 32'(cpu_run), 32'd1);
        checkOutput("csum good load_error", 32'(load_error), 32'd0);
        applyStimulus(1, 0, 8'h01);
        waitSettled("csum bad");
        checkOutput("csum bad load_error", 32'(load_error), 32'd1);
        checkOutput("csum bad cpu_run", 32'(cpu_run), 32'd0);
`endif

        // Reset after three of four words abandons the session.
        fillRandom(4);
        clearWrites();
        pulseStart(4);
        for (int i = 0; i < 6; i++) sendByte(txBytes[i], 0);
        bus.in_valid = 1'b0;
        @(posedge clock); #1;
        checkOutput("midreset writes", 32'(wrAddr.size()), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        checkAllZero("midreset");
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        fillRandom(1);
        applyStimulus(1, 0, 8'h00);
        waitSettled("after reset");
        checkSession(1, "after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
